// File: rtl/snapshot_reg_file_if.sv
// ---------------------------------------------------------------------------
// snapshot_reg_file_if
//
// Groups the decode read ports, the write-back port and the snapshot
// restore/handshake signals of snapshot_reg_file.
//
//   rs_addr / uses_rs / rs_data      read port A (data returned by slave)
//   rt_addr / uses_rt / rt_data      read port B (data returned by slave)
//   uses_rw / rw_addr / rw_data      write-back port
//   recover_snapshot                 level request: restore from regs_snapshot
//   recovery_done_ack                clears done
//   regs_snapshot                    restore image, reg i at [i*DATA_WIDTH +: DATA_WIDTH]
//   regs_out                         live register contents, same packing
//   done                             recovery-complete flag
//
// master : pipeline side (drives addresses, write data, restore controls)
// slave  : register file side
// ---------------------------------------------------------------------------
interface snapshot_reg_file_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  localparam int NUM_REGS = 2 ** ADDR_WIDTH;

  logic [ADDR_WIDTH-1:0]          rs_addr;
  logic                           uses_rs;
  logic [ADDR_WIDTH-1:0]          rt_addr;
  logic                           uses_rt;
  logic [DATA_WIDTH-1:0]          rs_data;
  logic [DATA_WIDTH-1:0]          rt_data;
  logic                           uses_rw;
  logic [ADDR_WIDTH-1:0]          rw_addr;
  logic [DATA_WIDTH-1:0]          rw_data;
  logic                           recover_snapshot;
  logic                           recovery_done_ack;
  logic [NUM_REGS*DATA_WIDTH-1:0] regs_snapshot;
  logic [NUM_REGS*DATA_WIDTH-1:0] regs_out;
  logic                           done;

  modport master (
    output rs_addr, uses_rs, rt_addr, uses_rt,
    output uses_rw, rw_addr, rw_data,
    output recover_snapshot, recovery_done_ack, regs_snapshot,
    input  rs_data, rt_data, regs_out, done
  );

  modport slave (
    input  rs_addr, uses_rs, rt_addr, uses_rt,
    input  uses_rw, rw_addr, rw_data,
    input  recover_snapshot, recovery_done_ack, regs_snapshot,
    output rs_data, rt_data, regs_out, done
  );
endinterface

// File: rtl/snapshot_reg_file.sv
// ---------------------------------------------------------------------------
// snapshot_reg_file
//
// MIPS architectural register file (2**ADDR_WIDTH x DATA_WIDTH) with two
// combinational read ports, one synchronous write port and a whole-file
// restore from a snapshot image for mispredict/exception recovery.
//
// Ports:
//   clk  - clock, all state changes on the rising edge
//   rst  - synchronous active-high reset (clears registers and done)
//   bus  - snapshot_reg_file_if.slave (read/write ports, restore image,
//          restore request, done/ack handshake, flat regs_out bus)
//
// Priority per edge: rst > recover_snapshot > write-back.
// Register 0 is hardwired to zero: it has no storage at all, so writes and
// restores can never make it nonzero.
//
// Optional build macro: SNAPSHOT_REG_FILE_WB_BYPASS_EN
//   When defined, read ports forward same-cycle write-back data (never for
//   address 0, never while a restore is requested). regs_out is never
//   bypassed. When undefined, reads return stored state only.
//
// DATA_WIDTH/ADDR_WIDTH must match the parameters of the connected interface.
// ---------------------------------------------------------------------------
module snapshot_reg_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic               clk,
  input  logic               rst,
  snapshot_reg_file_if.slave bus
);
  localparam int NUM_REGS = 2 ** ADDR_WIDTH;

  // Current contents of every register, index = register number.
  logic [DATA_WIDTH-1:0] regs_word [NUM_REGS];
  logic                  done_reg;

  // -------------------------------------------------------------------------
  // Register storage. Flops rather than RAM: every word is visible on
  // regs_out and all words load in parallel on a restore.
  // -------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      if (gi == 0) begin : g_zero
        assign regs_word[gi] = '0;
      end else begin : g_word
        logic [DATA_WIDTH-1:0] word_reg;
        logic                  wr_hit;

        assign wr_hit = bus.uses_rw && (bus.rw_addr == ADDR_WIDTH'(gi));

        always_ff @(posedge clk) begin
          if (rst) begin
            word_reg <= '0;
          end else if (bus.recover_snapshot) begin
            // Restore wins over a same-cycle write-back; the write is lost.
            word_reg <= bus.regs_snapshot[gi*DATA_WIDTH +: DATA_WIDTH];
          end else if (wr_hit) begin
            word_reg <= bus.rw_data;
          end
        end

        assign regs_word[gi] = word_reg;
      end

      assign bus.regs_out[gi*DATA_WIDTH +: DATA_WIDTH] = regs_word[gi];
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Recovery-complete flag. A pending restore request dominates the ack, so
  // an ack that overlaps the request does not clear done.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      done_reg <= 1'b0;
    end else if (bus.recover_snapshot) begin
      done_reg <= 1'b1;
    end else if (bus.recovery_done_ack) begin
      done_reg <= 1'b0;
    end
  end

  assign bus.done = done_reg;

  // -------------------------------------------------------------------------
  // Combinational read ports.
  // -------------------------------------------------------------------------
`ifdef SNAPSHOT_REG_FILE_WB_BYPASS_EN
  logic wb_fwd_ok;
  logic fwd_rs;
  logic fwd_rt;

  // Forwarding is off during a restore: the write will be dropped, so its
  // data must not be observed either.
  assign wb_fwd_ok = bus.uses_rw && !bus.recover_snapshot && (bus.rw_addr != '0);
  assign fwd_rs    = wb_fwd_ok && (bus.rw_addr == bus.rs_addr);
  assign fwd_rt    = wb_fwd_ok && (bus.rw_addr == bus.rt_addr);

  always_comb begin
    bus.rs_data = '0;
    bus.rt_data = '0;
    if (bus.uses_rs) begin
      bus.rs_data = fwd_rs ? bus.rw_data : regs_word[bus.rs_addr];
    end
    if (bus.uses_rt) begin
      bus.rt_data = fwd_rt ? bus.rw_data : regs_word[bus.rt_addr];
    end
  end
`else
  always_comb begin
    bus.rs_data = '0;
    bus.rt_data = '0;
    if (bus.uses_rs) begin
      bus.rs_data = regs_word[bus.rs_addr];
    end
    if (bus.uses_rt) begin
      bus.rt_data = regs_word[bus.rt_addr];
    end
  end
`endif

endmodule

// File: tb/tb_snapshot_reg_file.sv
// ---------------------------------------------------------------------------
// tb_snapshot_reg_file
//
// Directed bench for snapshot_reg_file: reset, read/write, register 0,
// read-during-write, restore, done/ack handshake and reset during recovery.
// Inputs change 1 time unit after the rising edge; outputs are sampled there.
// ---------------------------------------------------------------------------
module tb_snapshot_reg_file;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2 ** AW;
  localparam int VW = NR * DW;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  snapshot_reg_file_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  snapshot_reg_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [VW-1:0] exp_out;
  logic [DW-1:0] exp_rd;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    bus.rs_addr = '0; bus.uses_rs = 1'b0;
    bus.rt_addr = '0; bus.uses_rt = 1'b0;
    bus.uses_rw = 1'b0; bus.rw_addr = '0; bus.rw_data = '0;
    bus.recover_snapshot = 1'b0; bus.recovery_done_ack = 1'b0;
    bus.regs_snapshot = '0;

    // Reset
    tick();
    rst = 1'b0;
    bus.uses_rs = 1'b1; bus.rs_addr = 5'd7;
    #1;
    check("reset_rs7", VW'(bus.rs_data), VW'(0));
    check("reset_done", VW'(bus.done), VW'(0));
    check("reset_regs_out", bus.regs_out, '0);
    $display("reset: rs_data=%0h done=%0b", bus.rs_data, bus.done);

    // Write r5 then read it on port A
    bus.uses_rw = 1'b1; bus.rw_addr = 5'd5; bus.rw_data = 32'hDEADBEEF;
    tick();
    bus.uses_rw = 1'b0;
    bus.rs_addr = 5'd5;
    #1;
    check("wr_r5_rd", VW'(bus.rs_data), VW'(32'hDEADBEEF));
    bus.uses_rs = 1'b0;
    #1;
    check("rs_gated", VW'(bus.rs_data), VW'(0));
    exp_out = '0;
    exp_out[5*DW +: DW] = 32'hDEADBEEF;
    check("regs_out_r5", bus.regs_out, exp_out);
    $display("write r5: rs_data=%0h", 32'hDEADBEEF);

    // Write r31 and read on port B
    bus.uses_rw = 1'b1; bus.rw_addr = 5'd31; bus.rw_data = 32'hCAFEF00D;
    tick();
    bus.uses_rw = 1'b0;
    bus.uses_rt = 1'b1; bus.rt_addr = 5'd31;
    #1;
    check("wr_r31_rt", VW'(bus.rt_data), VW'(32'hCAFEF00D));
    $display("write r31: rt_data=%0h", bus.rt_data);

    // Write to r0 is discarded (also never forwarded)
    bus.uses_rw = 1'b1; bus.rw_addr = 5'd0; bus.rw_data = 32'h1234;
    bus.uses_rs = 1'b1; bus.rs_addr = 5'd0;
    #1;
    check("r0_no_fwd", VW'(bus.rs_data), VW'(0));
    tick();
    bus.uses_rw = 1'b0;
    check("r0_after_wr", VW'(bus.rs_data), VW'(0));
    $display("write r0: rs_data=%0h", bus.rs_data);

    // Read-during-write on r9
    bus.uses_rw = 1'b1; bus.rw_addr = 5'd9; bus.rw_data = 32'h11;
    tick();
    bus.rw_data = 32'h22;
    bus.uses_rt = 1'b1; bus.rt_addr = 5'd9;
    #1;
`ifdef SNAPSHOT_REG_FILE_WB_BYPASS_EN
    exp_rd = 32'h22;
`else
    exp_rd = 32'h11;
`endif
    check("rdw_before_edge", VW'(bus.rt_data), VW'(exp_rd));
    tick();
    bus.uses_rw = 1'b0;
    check("rdw_after_edge", VW'(bus.rt_data), VW'(32'h22));
    $display("read-during-write r9: after=%0h", bus.rt_data);

    // Restore with a competing write to r3
    for (int i = 0; i < NR; i++) bus.regs_snapshot[i*DW +: DW] = 32'h100 + i;
    bus.recover_snapshot = 1'b1;
    bus.uses_rw = 1'b1; bus.rw_addr = 5'd3; bus.rw_data = 32'hFFFF;
    bus.rs_addr = 5'd3;
    #1;
    check("done_before_restore", VW'(bus.done), VW'(0));
    check("no_fwd_during_restore", VW'(bus.rs_data), VW'(0));
    tick();
    bus.recover_snapshot = 1'b0;
    bus.uses_rw = 1'b0;
    bus.rt_addr = 5'd31;
    #1;
    check("restore_r3", VW'(bus.rs_data), VW'(32'h103));
    check("restore_r31", VW'(bus.rt_data), VW'(32'h11F));
    bus.rs_addr = 5'd0;
    #1;
    check("restore_r0", VW'(bus.rs_data), VW'(0));
    check("restore_done", VW'(bus.done), VW'(1));
    exp_out = '0;
    for (int i = 1; i < NR; i++) exp_out[i*DW +: DW] = 32'h100 + i;
    check("restore_regs_out", bus.regs_out, exp_out);
    $display("restore: r3=103 r31=11f done=%0b", bus.done);

    // Handshake: done holds without ack
    for (int k = 0; k < 3; k++) begin
      tick();
      check("done_hold", VW'(bus.done), VW'(1));
    end
    // Ack with restore still requested is ignored
    bus.recovery_done_ack = 1'b1; bus.recover_snapshot = 1'b1;
    tick();
    check("ack_during_restore", VW'(bus.done), VW'(1));
    // Ack alone clears done after the edge
    bus.recover_snapshot = 1'b0;
    #1;
    check("done_before_ack_edge", VW'(bus.done), VW'(1));
    tick();
    bus.recovery_done_ack = 1'b0;
    check("done_cleared", VW'(bus.done), VW'(0));
    tick();
    check("done_stays_clear", VW'(bus.done), VW'(0));
    $display("handshake: done=%0b", bus.done);

    // Normal write after recovery
    bus.uses_rw = 1'b1; bus.rw_addr = 5'd3; bus.rw_data = 32'h55;
    tick();
    bus.uses_rw = 1'b0;
    bus.rs_addr = 5'd3;
    #1;
    check("wr_after_restore", VW'(bus.rs_data), VW'(32'h55));
    $display("write r3 after restore: rs_data=%0h", bus.rs_data);

    // Reset together with restore request
    rst = 1'b1; bus.recover_snapshot = 1'b1;
    tick();
    rst = 1'b0; bus.recover_snapshot = 1'b0;
    #1;
    check("rst_mid_regs", bus.regs_out, '0);
    check("rst_mid_done", VW'(bus.done), VW'(0));
    check("rst_mid_rs3", VW'(bus.rs_data), VW'(0));
    $display("reset during recovery: done=%0b", bus.done);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/snapshot_reg_file.md
Name: snapshot_reg_file

Overview:
- MIPS-core architectural register file: 2^ADDR_WIDTH words of DATA_WIDTH bits.
- Two asynchronous read ports feed decode; one synchronous write port is driven by write-back.
- Adds a whole-file snapshot restore for mispredict/exception recovery, with a done/ack handshake, and exposes all registers as a flat bus for snapshot capture elsewhere.

Parameters:
- DATA_WIDTH, 32, width of each register.
- ADDR_WIDTH, 5, register address width; NUM_REGS = 2**ADDR_WIDTH = 32.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- rs_addr  input  ADDR_WIDTH  read port A address.
- uses_rs  input  1  read port A valid.
- rt_addr  input  ADDR_WIDTH  read port B address.
- uses_rt  input  1  read port B valid.
- rs_data  output  DATA_WIDTH  read port A data.
- rt_data  output  DATA_WIDTH  read port B data.
- uses_rw  input  1  write enable from write-back.
- rw_addr  input  ADDR_WIDTH  write address.
- rw_data  input  DATA_WIDTH  write data.
- recover_snapshot  input  1  level request to restore all registers from regs_snapshot.
- recovery_done_ack  input  1  acknowledge that clears done.
- regs_snapshot  input  NUM_REGS*DATA_WIDTH  restore image; register i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- regs_out  output  NUM_REGS*DATA_WIDTH  live contents of every register, same packing.
- done  output  1  recovery-complete flag.

Behaviour:
- Reset (rst high at clk edge):
  - all registers cleared to 0.
  - done cleared to 0.
  - reset has priority over recovery and write.
- Reads are combinational, with no clock latency:
  - rs_data = uses_rs ? reg[rs_addr] : 0.
  - rt_data = uses_rt ? reg[rt_addr] : 0.
- Register 0 is hardwired zero:
  - reads of address 0 return 0.
  - writes to address 0 are discarded.
  - restore forces reg 0 to 0 regardless of the snapshot's slot 0.
- Write: when uses_rw is high at a clk edge, reg[rw_addr] <= rw_data. The new value is visible on read ports and regs_out after that edge.
- Read-during-write to the same address (no bypass): the read returns the old value until the edge.
- Restore: when recover_snapshot is high at a clk edge, every register loads its regs_snapshot slot in that same edge.
  - A restore has priority over a same-cycle write-back; the write is dropped.
  - recover_snapshot held high re-restores every cycle.
- done state, updated per edge:
  - if recover_snapshot is high: done <= 1.
  - else if recovery_done_ack is high: done <= 0.
  - else done holds.
  - Consequently done rises the cycle after the first restore edge, coinciding with the restored values on regs_out.
  - An ack asserted while recover_snapshot is still high is ignored.
- regs_out always reflects the current register state; reg 0 slot is always 0.
- No X propagation: all outputs are defined from reset onward.

Optional Feature:
- Macro: SNAPSHOT_REG_FILE_WB_BYPASS_EN.
- When defined, the read ports forward write data: if uses_rw is high, rw_addr != 0, and rw_addr equals rs_addr (rt_addr), then rs_data (rt_data) = rw_data combinationally, subject to uses_rs (uses_rt) gating.
- Bypass is suppressed while recover_snapshot is high.
- regs_out is never bypassed.
- When undefined, reads return stored state only, as in Behaviour.

Test Plan:
- Reset then read: rst=1 for one edge, then uses_rs=1, rs_addr=7 -> rs_data=0; done=0; regs_out all 0.
- Write/read: write 0xDEADBEEF to r5, then uses_rs=1, rs_addr=5 -> rs_data=0xDEADBEEF. With uses_rs=0 -> rs_data=0. Write 0x1234 to r0 -> r0 reads 0.
- Same-cycle read/write: r9=0x11; assert write of 0x22 to r9 while reading r9 -> rt_data=0x11 before the edge and 0x22 after. With the bypass macro defined, 0x22 is seen immediately.
- Restore: regs_snapshot slot i = 0x100+i; pulse recover_snapshot for 1 cycle while writing 0xFFFF to r3 -> after the edge r3=0x103, r31=0x11F, r0=0; done=1 on the next cycle.
- Handshake: done=1; hold recovery_done_ack=0 for 3 cycles -> done stays 1. Assert ack with recover_snapshot high -> done stays 1. Assert ack with recover_snapshot low -> done=0 after the next edge.
- Reset mid-recovery: assert rst and recover_snapshot together -> registers 0, done 0.
